// File: rtl/add_arb_pkg.sv
// Shared definitions for the add_arbiter slice: datapath and id widths
// plus the output-register FSM state encoding.
package add_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ID_W   = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage : add_arb_pkg

// File: rtl/CLA.sv
// CLA: team carry-lookahead adder. Bits are handled in 4-bit groups; each
// group computes its internal carries and its group generate/propagate in
// two-level logic, and group carries chain from one group to the next.
// WIDTH must be a multiple of 4.
module CLA #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Generate/propagate per bit, lookahead carries per group, then sum bits
    always_comb begin
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH:0]   c;
        logic             grp_g;
        logic             grp_p;
        int               base;

        g     = a & b;
        p     = a ^ b;
        c     = '0;
        c[0]  = cin;
        grp_g = 1'b0;
        grp_p = 1'b0;
        base  = 0;

        for (int j = 0; j < WIDTH / 4; j++) begin
            base = 4 * j;
            c[base+1] = g[base]
                      | (p[base] & c[base]);
            c[base+2] = g[base+1]
                      | (p[base+1] & g[base])
                      | (p[base+1] & p[base] & c[base]);
            c[base+3] = g[base+2]
                      | (p[base+2] & g[base+1])
                      | (p[base+2] & p[base+1] & g[base])
                      | (p[base+2] & p[base+1] & p[base] & c[base]);
            grp_g = g[base+3]
                  | (p[base+3] & g[base+2])
                  | (p[base+3] & p[base+2] & g[base+1])
                  | (p[base+3] & p[base+2] & p[base+1] & g[base]);
            grp_p = p[base+3] & p[base+2] & p[base+1] & p[base];
            c[base+4] = grp_g | (grp_p & c[base]);
        end

        sum  = p ^ c[WIDTH-1:0];
        cout = c[WIDTH];
    end

endmodule : CLA

// File: rtl/rr_arb.sv
// rr_arb: combinational round-robin picker. The requester at index ptr has
// highest priority, then ptr+1, ... wrapping back to 0. Output is one-hot,
// or all-zero when nobody requests. ptr must be below N_REQ.
module rr_arb
    import add_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant
);

    // Walk the requesters starting at ptr and grant the first one found
    always_comb begin
        logic found;
        int   idx;

        grant = '0;
        found = 1'b0;
        idx   = 0;

        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && (k == idx) && req[k]) begin
                    grant[k] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule : rr_arb

// File: rtl/add_arbiter.sv
// add_arbiter: N_REQ requesters share one 32-bit CLA. A round-robin arbiter
// picks at most one requester per cycle; its result lands in a single
// output register one cycle later and is held until the consumer takes it.
// A new grant may be issued in the same cycle the held result is consumed,
// giving one result per cycle under no backpressure.
// Optional feature: define ADD_ARB_SUB_EN to add per-requester req_sub,
// which turns the operation into A + ~B + 1 (cout=1 means no borrow).
// N_REQ legal range is 2..8.
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ-1:0]        req_cin,
`ifdef ADD_ARB_SUB_EN
    input  logic [N_REQ-1:0]        req_sub,
`endif
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_sum,
    output logic                    rsp_cout,
    output logic [ID_W-1:0]         rsp_id
);

    state_t             state;
    state_t             state_next;
    logic [ID_W-1:0]    ptr;
    logic [N_REQ-1:0]   grant;
    logic               can_accept;
    logic               fire;
    logic [ID_W-1:0]    gnt_idx;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic               op_cin;
    logic [DATA_W-1:0]  add_b;
    logic               add_cin;
    logic [DATA_W-1:0]  add_sum;
    logic               add_cout;
`ifdef ADD_ARB_SUB_EN
    logic               op_sub;
`endif

    rr_arb #(
        .N_REQ (N_REQ)
    ) u_rr_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // The output register can take a new result when empty or being drained;
    // nothing is granted while reset is held
    always_comb begin
        can_accept = (state == EMPTY) || rsp_ready;
        req_ready  = grant & {N_REQ{can_accept && !rst}};
        fire       = |req_ready;
    end

    // Select the granted requester's operands and index from the one-hot grant
    always_comb begin
        gnt_idx = '0;
        op_a    = '0;
        op_b    = '0;
        op_cin  = 1'b0;
`ifdef ADD_ARB_SUB_EN
        op_sub  = 1'b0;
`endif
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                gnt_idx = ID_W'(k);
                op_a    = req_a[k*DATA_W +: DATA_W];
                op_b    = req_b[k*DATA_W +: DATA_W];
                op_cin  = req_cin[k];
`ifdef ADD_ARB_SUB_EN
                op_sub  = req_sub[k];
`endif
            end
        end
    end

    // Subtraction reuses the adder as A + ~B + 1, ignoring the requester's cin
    always_comb begin
`ifdef ADD_ARB_SUB_EN
        add_b   = op_sub ? ~op_b : op_b;
        add_cin = op_sub ? 1'b1 : op_cin;
`else
        add_b   = op_b;
        add_cin = op_cin;
`endif
    end

    CLA #(
        .WIDTH (DATA_W)
    ) u_cla (
        .a    (op_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Output-register occupancy state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // EMPTY fills on a grant; FULL drains on rsp_ready unless refilled
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (fire) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (rsp_ready && !fire) begin
                    state_next = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Capture the adder result on a transfer and move priority past the winner
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_id   <= '0;
            ptr      <= '0;
        end else if (fire) begin
            rsp_sum  <= add_sum;
            rsp_cout <= add_cout;
            rsp_id   <= gnt_idx;
            ptr      <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign rsp_valid = (state == FULL);

endmodule : add_arbiter

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed vectors for add_arbiter (N_REQ=4). The driver
// pushes the hand-computed result of every expected grant into a queue; a
// monitor on the falling edge pops and compares each consumed result.
// Define ADD_ARB_SUB_EN to also exercise the subtract path.
module tb_add_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic [2:0]  id;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N-1:0]    req_cin;
    logic [N-1:0]    req_sub;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_sum;
    logic            rsp_cout;
    logic [2:0]      rsp_id;

    logic [31:0]     a_arr [N];
    logic [31:0]     b_arr [N];

    exp_t            exp_q [$];
    int              total;
    int              bad;

    assign req_a = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
    assign req_b = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

    add_arbiter #(
        .N_REQ (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
`ifdef ADD_ARB_SUB_EN
        .req_sub   (req_sub),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setOperand(input int k, input logic [31:0] a, input logic [31:0] b,
                              input logic cin, input logic sub);
        a_arr[k]   = a;
        b_arr[k]   = b;
        req_cin[k] = cin;
        req_sub[k] = sub;
    endtask

    // One cycle of stimulus: drive after the rising edge, check the grant,
    // and queue the expected result when a transfer is expected
    task automatic applyStimulus(input logic rst_v, input logic [N-1:0] valid, input logic rdy,
                                 input int exp_id, input logic [31:0] exp_sum, input logic exp_cout);
        logic [N-1:0] exp_ready;
        exp_t         e;
        @(posedge clk);
        #1;
        rst       = rst_v;
        req_valid = valid;
        rsp_ready = rdy;
        if (rst_v) begin
            exp_q.delete();
        end
        #1;
        exp_ready = '0;
        if (exp_id >= 0) begin
            exp_ready[exp_id] = 1'b1;
        end
        checkValue("req_ready", 32'(req_ready), 32'(exp_ready));
        if (exp_id >= 0) begin
            e.sum  = exp_sum;
            e.cout = exp_cout;
            e.id   = 3'(exp_id);
            exp_q.push_back(e);
        end
    endtask

    task automatic checkOutput(input logic exp_valid, input logic [31:0] exp_sum,
                               input logic exp_cout, input logic [2:0] exp_id);
        checkValue("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        checkValue("rsp_sum", rsp_sum, exp_sum);
        checkValue("rsp_cout", 32'(rsp_cout), 32'(exp_cout));
        checkValue("rsp_id", 32'(rsp_id), 32'(exp_id));
    endtask

    // Monitor: every consumed result must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1 && rst === 1'b0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_rsp: got id=%0d sum=0x%08h, required no response",
                             rsp_id, rsp_sum);
                end else begin
                    e = exp_q.pop_front();
                    checkValue("mon_sum", rsp_sum, e.sum);
                    checkValue("mon_cout", 32'(rsp_cout), 32'(e.cout));
                    checkValue("mon_id", 32'(rsp_id), 32'(e.id));
                end
            end
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_cin   = '0;
        req_sub   = '0;
        for (int k = 0; k < N; k++) begin
            a_arr[k] = '0;
            b_arr[k] = '0;
        end

        // Reset: no grant even with every requester pending
        applyStimulus(1'b1, 4'b1111, 1'b0, -1, 32'h0, 1'b0);
        applyStimulus(1'b1, 4'b1111, 1'b0, -1, 32'h0, 1'b0);
        checkOutput(1'b0, 32'h0, 1'b0, 3'd0);

        // Fairness: all pending, consumer always ready -> 0,1,2,3,0
        setOperand(0, 32'h0000_0010, 32'h0000_0001, 1'b0, 1'b0);
        setOperand(1, 32'h0000_0020, 32'h0000_0002, 1'b1, 1'b0);
        setOperand(2, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        setOperand(3, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b1, 0, 32'h0000_0011, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b1, 1, 32'h0000_0023, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b1, 2, 32'h0000_0000, 1'b1);
        applyStimulus(1'b0, 4'b1111, 1'b1, 3, 32'h2345_678A, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b1, 0, 32'h0000_0011, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1, -1, 32'h0, 1'b0);

        // Single request on requester 0 (pointer is at 1, search wraps)
        setOperand(0, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0001, 1'b1, 0, 32'h0000_0008, 1'b0);

        // Wrap-around of the 32-bit sum on requester 2
        setOperand(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0100, 1'b1, 2, 32'h0000_0001, 1'b1);

        // Backpressure: requester 3 wins, then consumer stalls 3 cycles;
        // requester 3 drops its request meanwhile and requester 1 waits
        applyStimulus(1'b0, 4'b1010, 1'b1, 3, 32'h2345_678A, 1'b0);
        applyStimulus(1'b0, 4'b1010, 1'b0, -1, 32'h0, 1'b0);
        checkOutput(1'b1, 32'h2345_678A, 1'b0, 3'd3);
        applyStimulus(1'b0, 4'b0010, 1'b0, -1, 32'h0, 1'b0);
        checkOutput(1'b1, 32'h2345_678A, 1'b0, 3'd3);
        applyStimulus(1'b0, 4'b0010, 1'b0, -1, 32'h0, 1'b0);
        checkOutput(1'b1, 32'h2345_678A, 1'b0, 3'd3);
        applyStimulus(1'b0, 4'b0010, 1'b1, 1, 32'h0000_0023, 1'b0);

        // Reset while FULL discards the held result and restores priority 0
        applyStimulus(1'b0, 4'b0100, 1'b1, 2, 32'h0000_0001, 1'b1);
        applyStimulus(1'b1, 4'b1111, 1'b0, -1, 32'h0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1, -1, 32'h0, 1'b0);
        checkOutput(1'b0, 32'h0, 1'b0, 3'd0);
        applyStimulus(1'b0, 4'b1111, 1'b1, 0, 32'h0000_0008, 1'b0);

`ifdef ADD_ARB_SUB_EN
        // Subtract: 3 - 5 borrows, cin is ignored
        setOperand(1, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0010, 1'b1, 1, 32'hFFFF_FFFE, 1'b0);
`endif

        // Drain with a bounded number of idle cycles
        for (int i = 0; i < 8; i++) begin
            if (exp_q.size() != 0) begin
                applyStimulus(1'b0, 4'b0000, 1'b1, -1, 32'h0, 1'b0);
            end
        end
        applyStimulus(1'b0, 4'b0000, 1'b1, -1, 32'h0, 1'b0);
        checkValue("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_add_arbiter
